apb_slave_regbank: RTL and testbench

APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

---
 rtl/apb_slave_regbank_if.sv | 22 ++
 rtl/apb_slave_regbank.sv | 146 ++++++++++++++
 tb/tb_apb_slave_regbank.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between the bridge (master) and the register-bank slave.
// Carries the three-bit select vector so several slaves can share one bundle.
interface apb_slave_regbank_if;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB register bank: six R/W words, a committed-write counter and a constant ID.
// Transfers are stretched by WAIT_CYCLES wait states; all bus outputs are registered.
module apb_slave_regbank #(
    parameter int unsigned SEL_IDX     = 0,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA5B4_0001
) (
    input logic                hclk,
    input logic                hresetn,
    apb_slave_regbank_if.slave apb
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state_r, state_next_s;
    logic [3:0]  cnt_r, cnt_next_s;
    logic [9:0]  addr_r, addr_cur_s;
    logic        write_r, write_cur_s;
    logic [31:0] words_r [6];
    logic [15:0] wcnt_r;
    logic [31:0] prdata_r;
    logic        pready_r;
    logic        pslverr_r;
    logic        sel_s;
    logic        latch_s;
    logic        err_cur_s;
    logic        commit_s;
    logic [31:0] rd_word_s;
    logic        unused_s;

    // Out-of-range word address, or a write aimed at one of the read-only words 6/7.
    function automatic logic addr_error(input logic [9:0] word_addr, input logic is_write);
        return (word_addr[9:3] != 7'd0) || (is_write && (word_addr[2:1] == 2'b11));
    endfunction

    assign sel_s    = apb.psel[SEL_IDX];
    assign unused_s = ^{apb.psel, apb.paddr[31:12], apb.paddr[1:0]};

    // Next-state logic; the setup address is used directly on the cycle it is latched.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        latch_s      = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (sel_s && !apb.penable) begin
                    latch_s = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = WAIT;
                        cnt_next_s   = CNT_INIT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (sel_s && apb.penable) begin
                    if (cnt_r == 4'd0) begin
                        state_next_s = DONE;
                    end else begin
                        cnt_next_s = cnt_r - 4'd1;
                    end
                end else begin
                    state_next_s = IDLE;
                    cnt_next_s   = 4'd0;
                end
            end
            DONE: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
                commit_s     = sel_s && apb.penable && write_r && !err_cur_s;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Address/direction of the transfer in flight, its error status and read word.
    always_comb begin
        addr_cur_s  = latch_s ? apb.paddr[11:2] : addr_r;
        write_cur_s = latch_s ? apb.pwrite : write_r;
        err_cur_s   = addr_error(addr_cur_s, write_cur_s);
        case (addr_cur_s[2:0])
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: rd_word_s = words_r[addr_cur_s[2:0]];
            3'd6:    rd_word_s = {16'h0000, wcnt_r};
            3'd7:    rd_word_s = ID_VALUE;
            default: rd_word_s = 32'h0000_0000;
        endcase
    end

    // FSM state and wait-state counter.
    always_ff @(posedge hclk or posedge hresetn) begin
        if (hresetn) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Transfer capture, register file, write counter and registered bus outputs.
    always_ff @(posedge hclk or posedge hresetn) begin
        if (hresetn) begin
            addr_r    <= 10'd0;
            write_r   <= 1'b0;
            wcnt_r    <= 16'd0;
            prdata_r  <= 32'h0000_0000;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                words_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (latch_s) begin
                addr_r  <= apb.paddr[11:2];
                write_r <= apb.pwrite;
            end
            if (commit_s) begin
                case (addr_r[2:0])
                    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: words_r[addr_r[2:0]] <= apb.pwdata;
                    default: ;
                endcase
                wcnt_r <= wcnt_r + 16'd1;
            end
            pready_r  <= (state_next_s == DONE);
            pslverr_r <= (state_next_s == DONE) && err_cur_s;
            prdata_r  <= ((state_next_s == DONE) && !write_cur_s && !err_cur_s) ? rd_word_s
                                                                                : 32'h0000_0000;
        end
    end

    assign apb.prdata  = prdata_r;
    assign apb.pready  = pready_r;
    assign apb.pslverr = pslverr_r;
endmodule

// File: tb/tb_apb_slave_regbank.sv
// Two register-bank slaves on one APB bus: slave 0 (psel[0], 2 wait states)
// and slave 1 (psel[1], no wait states), checked by directed vectors and a reference model.
module tb_apb_slave_regbank;
    localparam int          A_WAIT = 2;
    localparam int          B_WAIT = 0;
    localparam logic [31:0] ID     = 32'hA5B4_0001;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    int n_vec = 0;
    int n_err = 0;

    apb_slave_regbank_if ifa ();
    apb_slave_regbank_if ifb ();

    assign ifa.psel = psel;  assign ifb.psel = psel;
    assign ifa.penable = penable;  assign ifb.penable = penable;
    assign ifa.pwrite = pwrite;  assign ifb.pwrite = pwrite;
    assign ifa.paddr = paddr;  assign ifb.paddr = paddr;
    assign ifa.pwdata = pwdata;  assign ifb.pwdata = pwdata;

    apb_slave_regbank #(.SEL_IDX(0), .WAIT_CYCLES(A_WAIT), .ID_VALUE(ID)) dut_a (
        .hclk(hclk), .hresetn(hresetn), .apb(ifa)
    );
    apb_slave_regbank #(.SEL_IDX(1), .WAIT_CYCLES(B_WAIT), .ID_VALUE(ID)) dut_b (
        .hclk(hclk), .hresetn(hresetn), .apb(ifb)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        int          s;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_acc;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] mw [2][8];
    int          mc [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int s, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input bit chk_rd,
                           input logic [31:0] exp_rd, input bit exp_err, input int exp_acc);
        vec_t v;
        v.s = s; v.wr = wr; v.addr = addr; v.data = data;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_acc = exp_acc;
        vecs.push_back(v);
    endtask

    task automatic bus_idle();
        @(negedge hclk);
        psel = 3'b000; penable = 1'b0;
    endtask

    // One full APB transfer to slave s; acc counts access cycles up to and including pready.
    task automatic xfer(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rd, output bit er, output int acc);
        bit done;
        bit other_rdy;
        @(negedge hclk);
        psel    = (s == 0) ? 3'b001 : 3'b010;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(negedge hclk);
        penable   = 1'b1;
        acc       = 1;
        done      = 1'b0;
        other_rdy = 1'b0;
        rd        = 32'h0;
        er        = 1'b0;
        while (!done && acc <= 20) begin
            if (((s == 0) ? ifb.pready : ifa.pready) == 1'b1) other_rdy = 1'b1;
            if (((s == 0) ? ifa.pready : ifb.pready) == 1'b1) begin
                rd   = (s == 0) ? ifa.prdata : ifb.prdata;
                er   = (s == 0) ? ifa.pslverr : ifb.pslverr;
                done = 1'b1;
            end else begin
                @(negedge hclk);
                acc++;
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL xfer_timeout: slave %0d addr %0h got no pready, required within 20 cycles", s, addr);
            psel = 3'b000; penable = 1'b0;
        end
        check("other_slave_pready", {63'd0, other_rdy}, 64'd0);
    endtask

    // Reference model: word map and error rules applied to arrays.
    task automatic model_xfer(input int s, input bit wr, input logic [31:0] addr,
                              input logic [31:0] data, output logic [31:0] exp_rd, output bit exp_err);
        int idx;
        idx     = int'(addr[4:2]);
        exp_err = (addr[11:5] != 7'd0) || (wr && idx >= 6);
        exp_rd  = 32'h0;
        if (wr) begin
            if (!exp_err) begin
                mw[s][idx] = data;
                mc[s]      = (mc[s] + 1) % 65536;
            end
        end else if (!exp_err) begin
            if (idx == 6)      exp_rd = 32'(mc[s]);
            else if (idx == 7) exp_rd = ID;
            else               exp_rd = mw[s][idx];
        end
    endtask

    initial begin
        logic [31:0] rd, exp_rd;
        bit          er, exp_err;
        int          acc, cnt, s;
        bit          wr, seen;
        logic [31:0] addr, data;

        hresetn = 1'b1;
        psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        repeat (3) @(negedge hclk);
        check("reset_a_outputs", {30'd0, ifa.prdata, ifa.pready, ifa.pslverr}, 64'd0);
        check("reset_b_outputs", {30'd0, ifb.prdata, ifb.pready, ifb.pslverr}, 64'd0);
        hresetn = 1'b0;

        // Directed vectors from a fresh reset (slave 0: 3 access cycles, slave 1: 1).
        add_vec(0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 3);
        add_vec(0, 1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 3);
        add_vec(0, 1'b0, 32'h0000_0018, 32'h0,         1'b1, 32'h0000_0001, 1'b0, 3);
        add_vec(0, 1'b0, 32'h0000_001C, 32'h0,         1'b1, 32'hA5B4_0001, 1'b0, 3);
        add_vec(0, 1'b1, 32'h0000_001C, 32'h1234_5678, 1'b0, 32'h0,         1'b1, 3);
        add_vec(0, 1'b0, 32'h0000_001C, 32'h0,         1'b1, 32'hA5B4_0001, 1'b0, 3);
        add_vec(0, 1'b0, 32'h0000_0018, 32'h0,         1'b1, 32'h0000_0001, 1'b0, 3);
        add_vec(0, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h0,         1'b1, 3);
        add_vec(1, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,         1'b0, 1);
        add_vec(1, 1'b1, 32'h0000_0008, 32'h2222_2222, 1'b0, 32'h0,         1'b0, 1);
        add_vec(1, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111, 1'b0, 1);
        add_vec(1, 1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h2222_2222, 1'b0, 1);
        add_vec(1, 1'b0, 32'h0000_0018, 32'h0,         1'b1, 32'h0000_0002, 1'b0, 1);
        add_vec(0, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0,         1'b0, 3);
        add_vec(0, 1'b0, 32'h0000_0007, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 3);
        add_vec(0, 1'b1, 32'h0000_0018, 32'h0BAD_0BAD, 1'b0, 32'h0,         1'b1, 3);
        add_vec(0, 1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'h0,         1'b1, 3);
        add_vec(1, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h1111_1111, 1'b0, 1);

        foreach (vecs[i]) begin
            xfer(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].data, rd, er, acc);
            check("tbl_pslverr", {63'd0, er}, {63'd0, vecs[i].exp_err});
            check("tbl_latency", 64'(acc), 64'(vecs[i].exp_acc));
            if (vecs[i].chk_rd) check("tbl_prdata", {32'd0, rd}, {32'd0, vecs[i].exp_rd});
        end
        bus_idle();

        // Select bit that belongs to neither slave: nobody may answer.
        @(negedge hclk);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFFFF_FFFF;
        seen = 1'b0;
        @(negedge hclk);
        penable = 1'b1;
        repeat (5) begin
            if (ifa.pready || ifb.pready) seen = 1'b1;
            @(negedge hclk);
        end
        check("foreign_sel_pready", {63'd0, seen}, 64'd0);
        bus_idle();

        // penable dropped during wait states on slave 0: abort, no write.
        @(negedge hclk);
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hCAFE_F00D;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        penable = 1'b0;
        @(negedge hclk);
        psel = 3'b000;
        check("abort_wait_pready", {63'd0, ifa.pready}, 64'd0);
        @(negedge hclk);
        check("abort_wait_pready2", {63'd0, ifa.pready}, 64'd0);
        xfer(0, 1'b0, 32'h0000_0000, 32'h0, rd, er, acc);
        check("abort_wait_word0", {32'd0, rd}, 64'd0);
        xfer(0, 1'b0, 32'h0000_0018, 32'h0, rd, er, acc);
        check("abort_wait_wcnt", {32'd0, rd}, 64'd1);

        // psel dropped in the DONE cycle on slave 1: no commit.
        @(negedge hclk);
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h7777_7777;
        @(negedge hclk);
        penable = 1'b1;
        check("abort_done_pready", {63'd0, ifb.pready}, 64'd1);
        psel = 3'b000;
        @(negedge hclk);
        check("abort_done_pready_low", {63'd0, ifb.pready}, 64'd0);
        xfer(1, 1'b0, 32'h0000_0004, 32'h0, rd, er, acc);
        check("abort_done_word1", {32'd0, rd}, 64'd0);
        xfer(1, 1'b0, 32'h0000_0018, 32'h0, rd, er, acc);
        check("abort_done_wcnt", {32'd0, rd}, 64'd2);

        // Reset pulsed while slave 0 is in a wait state.
        @(negedge hclk);
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h5555_AAAA;
        @(negedge hclk);
        penable = 1'b1;
        hresetn = 1'b1;
        #1;
        check("rst_wait_outputs", {30'd0, ifa.prdata, ifa.pready, ifa.pslverr}, 64'd0);
        @(negedge hclk);
        hresetn = 1'b0; psel = 3'b000; penable = 1'b0;
        xfer(0, 1'b0, 32'h0000_0004, 32'h0, rd, er, acc);
        check("rst_wait_word1", {32'd0, rd}, 64'd0);
        check("rst_first_latency", 64'(acc), 64'(A_WAIT + 1));
        xfer(0, 1'b0, 32'h0000_000C, 32'h0, rd, er, acc);
        check("rst_wait_word3", {32'd0, rd}, 64'd0);
        xfer(0, 1'b0, 32'h0000_0018, 32'h0, rd, er, acc);
        check("rst_wait_wcnt", {32'd0, rd}, 64'd0);
        xfer(1, 1'b0, 32'h0000_0008, 32'h0, rd, er, acc);
        check("rst_wait_b_word2", {32'd0, rd}, 64'd0);

        // Reset during a DONE cycle clears the outputs without waiting for a clock edge.
        @(negedge hclk);
        psel = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 32'h1C;
        @(negedge hclk);
        penable = 1'b1;
        cnt = 1;
        while (!ifa.pready && cnt < 20) begin
            @(negedge hclk);
            cnt++;
        end
        check("rst_done_prdata", {32'd0, ifa.prdata}, {32'd0, ID});
        hresetn = 1'b1;
        #1;
        check("rst_done_async", {30'd0, ifa.prdata, ifa.pready, ifa.pslverr}, 64'd0);
        @(negedge hclk);
        hresetn = 1'b0; psel = 3'b000; penable = 1'b0;

        // Randomized traffic against the reference model.
        for (int m = 0; m < 2; m++) begin
            mc[m] = 0;
            for (int w = 0; w < 8; w++) mw[m][w] = 32'h0;
        end
        for (int i = 0; i < 300; i++) begin
            s    = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(5, 11));
            if ($urandom_range(0, 7) == 0) addr = addr | 32'h0001_0000;
            data = $urandom;
            model_xfer(s, wr, addr, data, exp_rd, exp_err);
            xfer(s, wr, addr, data, rd, er, acc);
            check("rnd_pslverr", {63'd0, er}, {63'd0, exp_err});
            check("rnd_latency", 64'(acc), 64'((s == 0) ? A_WAIT + 1 : B_WAIT + 1));
            if (!wr) check("rnd_prdata", {32'd0, rd}, {32'd0, exp_rd});
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        bus_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
